serial_neg_ctrl: RTL and testbench
==================================

SERIAL_NEG_CTRL -- requirements
Module: serial_neg_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the word length in bits (legal range 2..32).
REQ-002 SHALL have port t_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a parallel word is offered on din.
REQ-005 SHALL have port in_ready, output, 1 bit: the controller can accept a word.
REQ-006 SHALL have port din, input, WIDTH bits: two's-complement word to negate.
REQ-007 SHALL have port ser_i, output, 1 bit: serial bit to the external two's-complement bit-serial datapath, LSB first.
REQ-008 SHALL have port ser_clr, output, 1 bit: word-start marker to the datapath's r input.
REQ-009 SHALL have port ser_y, input, 1 bit: combinational serial result from the datapath for the current ser_i.
REQ-010 SHALL have port out_valid, output, 1 bit: dout and out_ovf hold a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port dout, output, WIDTH bits: the negated word.
REQ-013 SHALL have port out_ovf, output, 1 bit: the negation overflowed (din was the most-negative value).

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-015 In IDLE: in_ready=1, ser_clr=1, ser_i=0; when in_valid=1, the controller SHALL load din into a shift register, clear bit_cnt to 0, latch ovf_flag = (din == 1 followed by WIDTH-1 zeros), and go to SHIFT.
REQ-016 In SHIFT: ser_i SHALL equal the shift register bit 0.
REQ-017 In SHIFT: ser_clr SHALL be 1 only while bit_cnt==0, i.e. on the LSB cycle, and 0 otherwise.
REQ-018 Each SHIFT cycle SHALL sample ser_y at the rising edge, shift it into the result register from the MSB side (shift right), shift the input register right, and increment bit_cnt.
REQ-019 When bit_cnt==WIDTH-1 at the edge, the FSM SHALL go to DONE; the result register then holds the full WIDTH-bit result, with bit k taken from SHIFT cycle k.
REQ-020 In DONE: out_valid=1, dout=result register, out_ovf=ovf_flag, in_ready=0, ser_clr=1, ser_i=0; dout and out_ovf SHALL stay stable until the handshake completes.
REQ-021 In DONE with out_ready=1, the FSM SHALL go to IDLE at the edge; there is no IDLE bypass.
REQ-022 Timing: in_ready and out_valid SHALL be mutually exclusive; in_ready SHALL be 0 in SHIFT and DONE, and in_valid is ignored there.
REQ-023 Latency: out_valid SHALL rise exactly WIDTH+1 edges after the accepting edge; minimum word-to-word period is WIDTH+2 cycles.
REQ-024 bit_cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within a word.
REQ-025 A most-negative input SHALL return dout=din with out_ovf=1; every other input SHALL give out_ovf=0.
REQ-026 Outputs SHALL be registered state decodes only; ser_y SHALL NOT propagate combinationally to any output.
REQ-027 t_clk period SHALL be at least 100 ns so that the datapath's gate-delay path settles before sampling.

Reset
REQ-028 When r=1 at an edge, the FSM SHALL go to IDLE from any state, including mid-SHIFT or DONE, discarding any partial or unconsumed word.
REQ-029 Reset values: in_ready=1, out_valid=0, dout=0, out_ovf=0, ser_clr=1, ser_i=0, bit_cnt=0, both shift registers 0.
REQ-030 r SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-031 The bench SHALL instantiate the gate-level serial negator as the datapath and cover the following scenarios at WIDTH=8:
- din=0x05 -> out_valid after 9 edges; dout=0xFB, out_ovf=0; ser_clr high on the first SHIFT cycle only.
- din=0x80 -> dout=0x80, out_ovf=1.
- din=0x00 -> dout=0x00, out_ovf=0.
- din=0x01 -> dout=0xFF.
- out_ready=0 held for 5 cycles in DONE -> dout and out_valid stable, in_ready=0; then out_ready=1 -> IDLE next edge.
- r=1 at bit_cnt=3 with din=0x3C -> next cycle IDLE, out_valid=0; then din=0x3C -> dout=0xC4.
- Continuous in_valid with out_ready=1 over the sequence 0x7F, 0xFF, 0x10 -> results 0x81, 0x01, 0xF0 in order, each 10 cycles apart.

Source files
------------

// File: rtl/serial_neg_ctrl.sv
// Word-level controller for an external bit-serial two's-complement negator:
// accepts a parallel word, streams it LSB first, and collects the serial result.
module serial_neg_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             t_clk,
   input  logic             r,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   output logic             ser_i,
   output logic             ser_clr,
   input  logic             ser_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             out_ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] src_q, src_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   always_ff @(posedge t_clk) begin
      if (r) begin
         state_q <= IDLE;
         src_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      ser_clr   = 1'b1;
      ser_i     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               src_d   = din;
               cnt_d   = '0;
               ovf_d   = (din == MOST_NEG);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            ser_i   = src_q[0];
            ser_clr = (cnt_q == '0);
            // Result fills from the MSB side so bit k lands from cycle k.
            res_d   = {ser_y, res_q[WIDTH-1:1]};
            src_d   = src_q >> 1;
            if (cnt_q == LAST_BIT) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dout    = res_q;
   assign out_ovf = ovf_q & (state_q == DONE);

endmodule

// File: tb/tb_serial_neg_ctrl.sv
// Directed bench for serial_neg_ctrl with a gate-level serial negator
// (y = x XOR "a one has been seen in lower bits") closing the loop.
module tb_serial_neg_ctrl;

   logic       t_clk = 1'b0;
   logic       r = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] din = 8'h00;
   logic       ser_i;
   logic       ser_clr;
   logic       ser_y;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] dout;
   logic       out_ovf;

   int errors = 0;
   int checks = 0;

   always #50 t_clk = ~t_clk;

   serial_neg_ctrl #(.WIDTH(8)) dut (
      .t_clk     (t_clk),
      .r         (r),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .ser_i     (ser_i),
      .ser_clr   (ser_clr),
      .ser_y     (ser_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .out_ovf   (out_ovf)
   );

   // Gate-level serial negator; ser_clr marks the LSB of a new word.
   logic seen_q = 1'b0;
   wire  clr_n;
   wire  seen_eff;
   wire  seen_nxt;
   not g_inv (clr_n, ser_clr);
   and g_and (seen_eff, seen_q, clr_n);
   xor g_xor (ser_y, ser_i, seen_eff);
   or  g_or  (seen_nxt, seen_eff, ser_i);
   always @(posedge t_clk) seen_q <= seen_nxt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at a negedge back in IDLE.
   task automatic do_word(input logic [7:0] d, input logic [7:0] exp_d,
                          input logic exp_ovf, input int hold);
      int edges;
      int clr_hits;
      logic [7:0] held;
      check_eq("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      din      = d;
      @(negedge t_clk);
      edges    = 1;
      clr_hits = 0;
      in_valid = 1'b0;
      din      = 8'hA5;
      while (!out_valid && edges < 40) begin
         if (!in_ready && ser_clr) clr_hits++;
         @(negedge t_clk);
         edges++;
      end
      $display("word din=0x%02h dout=0x%02h ovf=%0d latency=%0d", d, dout, out_ovf, edges);
      check_eq("latency", 32'(edges), 32'd9);
      check_eq("clr_first_only", 32'(clr_hits), 32'd1);
      check_eq("dout", 32'(dout), 32'(exp_d));
      check_eq("out_ovf", 32'(out_ovf), 32'(exp_ovf));
      check_eq("done_in_ready", 32'(in_ready), 32'd0);
      held = dout;
      for (int i = 0; i < hold; i++) begin
         @(negedge t_clk);
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_dout", 32'(dout), 32'(held));
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge t_clk);
      out_ready = 1'b0;
      check_eq("back_idle_valid", 32'(out_valid), 32'd0);
      check_eq("back_idle_ready", 32'(in_ready), 32'd1);
   endtask

   logic [7:0] seq_in  [3] = '{8'h7F, 8'hFF, 8'h10};
   logic [7:0] seq_exp [3] = '{8'h81, 8'h01, 8'hF0};

   initial begin
      int k;
      int n_res;
      int last_c;
      repeat (2) @(negedge t_clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_ovf", 32'(out_ovf), 32'd0);
      check_eq("rst_ser_clr", 32'(ser_clr), 32'd1);
      check_eq("rst_ser_i", 32'(ser_i), 32'd0);
      r = 1'b0;
      @(negedge t_clk);

      do_word(8'h05, 8'hFB, 1'b0, 0);
      do_word(8'h80, 8'h80, 1'b1, 0);
      do_word(8'h00, 8'h00, 1'b0, 0);
      do_word(8'h01, 8'hFF, 1'b0, 5);

      // Reset mid-SHIFT (bit_cnt=3), with in_valid also high.
      in_valid = 1'b1;
      din      = 8'h3C;
      @(negedge t_clk);
      in_valid = 1'b0;
      repeat (3) @(negedge t_clk);
      check_eq("pre_rst_shift", 32'(in_ready), 32'd0);
      r        = 1'b1;
      in_valid = 1'b1;
      @(negedge t_clk);
      r        = 1'b0;
      in_valid = 1'b0;
      $display("reset mid-word: in_ready=%0d out_valid=%0d dout=0x%02h", in_ready, out_valid, dout);
      check_eq("rst_mid_ready", 32'(in_ready), 32'd1);
      check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
      check_eq("rst_mid_dout", 32'(dout), 32'd0);
      do_word(8'h3C, 8'hC4, 1'b0, 0);

      // Back-to-back stream with out_ready held high.
      k         = 0;
      n_res     = 0;
      last_c    = -1;
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (out_valid) begin
            $display("stream result %0d dout=0x%02h cycle=%0d", n_res, dout, c);
            if (n_res < 3) check_eq("stream_dout", 32'(dout), 32'(seq_exp[n_res]));
            if (last_c >= 0) check_eq("stream_gap", 32'(c - last_c), 32'd10);
            last_c = c;
            n_res++;
         end
         if (in_ready) begin
            if (k < 3) begin
               in_valid = 1'b1;
               din      = seq_in[k];
               k++;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge t_clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_eq("stream_count", 32'(n_res), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
